// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the requester push handshake and the common data
// bus broadcast for cdb_arbiter.
//   master : execution-unit side; drives req_*, observes req_ready and wb_*.
//   slave  : arbiter side; consumes req_*, drives req_ready and wb_*.
// Packed buses hold requester i (or slot k) at bit offset i*width.
interface cdb_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int WB_PORTS      = 2,
  parameter int ROB_IDX_WIDTH = 5
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ*ROB_IDX_WIDTH-1:0]   req_rob_idx;
  logic [NUM_REQ*5-1:0]               req_rd_addr;
  logic [NUM_REQ*32-1:0]              req_data;
  logic [WB_PORTS-1:0]                wb_valid;
  logic [WB_PORTS*2-1:0]              wb_src;
  logic [WB_PORTS*ROB_IDX_WIDTH-1:0]  wb_rob_idx;
  logic [WB_PORTS*5-1:0]              wb_rd_addr;
  logic [WB_PORTS*32-1:0]             wb_data;

  modport master (
    output req_valid, req_rob_idx, req_rd_addr, req_data,
    input  req_ready, wb_valid, wb_src, wb_rob_idx, wb_rd_addr, wb_data
  );

  modport slave (
    input  req_valid, req_rob_idx, req_rd_addr, req_data,
    output req_ready, wb_valid, wb_src, wb_rob_idx, wb_rd_addr, wb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus writeback scheduler.
// Each execution unit (0=alu, 1=mul, 2=br, 3=mem) pushes results into its own
// small FIFO; every cycle up to WB_PORTS non-empty FIFOs are granted in
// round-robin order starting at rr_ptr and their heads are broadcast.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst   : asynchronous active-low reset
//   flush : synchronous pipeline flush (empties FIFOs, rr_ptr to 0)
//   bus   : cdb_arbiter_if.slave (req_* push side, wb_* broadcast side)
//   perf_stall_cnt : per-requester stall counters, only when
//                    CDB_ARBITER_PERF_EN is defined
module cdb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int FIFO_DEPTH    = 2,
  parameter int WB_PORTS      = 2,
  parameter int ROB_IDX_WIDTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  cdb_arbiter_if.slave bus
`ifdef CDB_ARBITER_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0] perf_stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic [4:0]               rd_addr;
    logic [31:0]              data;
  } entry_t;

  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] not_empty;
  entry_t             head [NUM_REQ];

  logic [RR_W-1:0] rr_ptr_reg;
  logic [RR_W-1:0] rr_ptr_next;

  logic [WB_PORTS-1:0]               wb_valid_next;
  logic [WB_PORTS*2-1:0]             wb_src_next;
  logic [WB_PORTS*ROB_IDX_WIDTH-1:0] wb_rob_idx_next;
  logic [WB_PORTS*5-1:0]             wb_rd_addr_next;
  logic [WB_PORTS*32-1:0]            wb_data_next;

  // Per-requester FIFOs. Ready looks only at the registered count, so a full
  // FIFO refuses a push even in a cycle where it is also popped.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    entry_t           mem_reg [FIFO_DEPTH];

    assign ready[gi]     = rst && (count_reg != CNT_W'(FIFO_DEPTH)) && !flush;
    assign push[gi]      = bus.req_valid[gi] && ready[gi];
    assign not_empty[gi] = (count_reg != '0);
    assign head[gi]      = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
      if (push[gi]) begin
        mem_reg[wr_ptr_reg] <= {bus.req_rob_idx[gi*ROB_IDX_WIDTH +: ROB_IDX_WIDTH],
                                bus.req_rd_addr[gi*5 +: 5],
                                bus.req_data[gi*32 +: 32]};
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else if (flush) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        // FIFO_DEPTH is a power of two, so pointers wrap naturally.
        if (push[gi])  wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (grant[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push[gi], grant[gi]})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end

`ifdef CDB_ARBITER_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stall_cnt_reg <= '0;
      end else if (not_empty[gi] && !grant[gi] && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end

    assign perf_stall_cnt[gi*32 +: 32] = stall_cnt_reg;
`endif
  end

  // Round-robin scan from rr_ptr; the k-th non-empty FIFO found fills slot k.
  // Grants are suppressed during flush, which also keeps the bus quiet.
  always_comb begin
    int slot;
    int idx;
    grant           = '0;
    wb_valid_next   = '0;
    wb_src_next     = '0;
    wb_rob_idx_next = '0;
    wb_rd_addr_next = '0;
    wb_data_next    = '0;
    rr_ptr_next     = rr_ptr_reg;
    slot            = 0;
    idx             = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = int'(rr_ptr_reg) + o;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!flush && not_empty[idx] && (slot < WB_PORTS)) begin
        grant[idx]                                        = 1'b1;
        wb_valid_next[slot]                               = 1'b1;
        wb_src_next[slot*2 +: 2]                          = 2'(idx);
        wb_rob_idx_next[slot*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] = head[idx].rob_idx;
        wb_rd_addr_next[slot*5 +: 5]                      = head[idx].rd_addr;
        wb_data_next[slot*32 +: 32]                       = head[idx].data;
        rr_ptr_next                                       = RR_W'((idx + 1) % NUM_REQ);
        slot                                              = slot + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
    end else if (flush) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.wb_valid   = wb_valid_next;
  assign bus.wb_src     = wb_src_next;
  assign bus.wb_rob_idx = wb_rob_idx_next;
  assign bus.wb_rd_addr = wb_rd_addr_next;
  assign bus.wb_data    = wb_data_next;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven directed bench for cdb_arbiter plus hand
// sequences for reset, the single-push latency case, mid-operation reset and
// (when CDB_ARBITER_PERF_EN is defined) the stall counters.
module tb_cdb_arbiter;
  localparam int NUM_REQ       = 4;
  localparam int FIFO_DEPTH    = 2;
  localparam int WB_PORTS      = 2;
  localparam int ROB_IDX_WIDTH = 5;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(
    .NUM_REQ(NUM_REQ), .WB_PORTS(WB_PORTS), .ROB_IDX_WIDTH(ROB_IDX_WIDTH)
  ) bus ();

`ifdef CDB_ARBITER_PERF_EN
  logic [NUM_REQ*32-1:0] perf;
`endif

  cdb_arbiter #(
    .NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH),
    .WB_PORTS(WB_PORTS), .ROB_IDX_WIDTH(ROB_IDX_WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef CDB_ARBITER_PERF_EN
    ,
    .perf_stall_cnt (perf)
`endif
  );

  int checks = 0;
  int errors = 0;

  // One row = inputs held for one cycle and the outputs expected in that
  // same cycle (before the edge that consumes the inputs).
  typedef struct packed {
    logic [3:0] valid;
    logic       flush;
    logic [4:0] base;      // requester i pushes rob index base+i
    logic [3:0] exp_ready;
    logic [1:0] exp_wbv;
    logic [1:0] src0;
    logic [4:0] rob0;
    logic [1:0] src1;
    logic [4:0] rob1;
  } vec_t;

  vec_t vecs [25];

  function automatic logic [4:0] rd_of(input logic [4:0] rob);
    return rob ^ 5'h15;
  endfunction

  function automatic logic [31:0] data_of(input logic [4:0] rob);
    return {24'hC0DE00, 3'b000, rob};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] valid, input logic [4:0] base);
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [4:0] rob;
      rob = base + 5'(i);
      bus.req_valid[i]                                      = valid[i];
      bus.req_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH]      = rob;
      bus.req_rd_addr[i*5 +: 5]                             = rd_of(rob);
      bus.req_data[i*32 +: 32]                              = data_of(rob);
    end
  endtask

  task automatic check_slot(input string tag, input int k, input logic v,
                            input logic [1:0] src, input logic [4:0] rob);
    chk($sformatf("%s slot%0d src", tag, k), 32'(bus.wb_src[k*2 +: 2]), v ? 32'(src) : 32'd0);
    chk($sformatf("%s slot%0d rob", tag, k), 32'(bus.wb_rob_idx[k*5 +: 5]), v ? 32'(rob) : 32'd0);
    chk($sformatf("%s slot%0d rd", tag, k), 32'(bus.wb_rd_addr[k*5 +: 5]), v ? 32'(rd_of(rob)) : 32'd0);
    chk($sformatf("%s slot%0d data", tag, k), bus.wb_data[k*32 +: 32], v ? data_of(rob) : 32'd0);
  endtask

  task automatic do_reset();
    drive(4'b0000, 5'd0);
    flush = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             valid  fl  base  ready  wbv  s0  rob0  s1  rob1
    vecs = '{
      '{4'b1111, 1'b0, 5'd8,  4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // A all push
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b11, 2'd0, 5'd8,  2'd1, 5'd9 },  // B alu,mul
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b11, 2'd2, 5'd10, 2'd3, 5'd11},  // C br,mem
      '{4'b1010, 1'b0, 5'd16, 4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // D mul17 mem19
      '{4'b0001, 1'b0, 5'd20, 4'b1111, 2'b11, 2'd1, 5'd17, 2'd3, 5'd19},  // E rr wrapped to 0
      '{4'b0100, 1'b0, 5'd24, 4'b1111, 2'b01, 2'd0, 5'd20, 2'd0, 5'd0 },  // F
      '{4'b0001, 1'b0, 5'd28, 4'b1111, 2'b01, 2'd2, 5'd26, 2'd0, 5'd0 },  // G
      '{4'b1000, 1'b0, 5'd0,  4'b1111, 2'b01, 2'd0, 5'd28, 2'd0, 5'd0 },  // H
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b01, 2'd3, 5'd3,  2'd0, 5'd0 },  // I
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // J
      '{4'b1111, 1'b0, 5'd4,  4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // K
      '{4'b1111, 1'b0, 5'd8,  4'b1111, 2'b11, 2'd0, 5'd4,  2'd1, 5'd5 },  // L br/mem fill
      '{4'b0000, 1'b0, 5'd0,  4'b0011, 2'b11, 2'd2, 5'd6,  2'd3, 5'd7 },  // M br/mem full
      '{4'b1000, 1'b0, 5'd12, 4'b1111, 2'b11, 2'd0, 5'd8,  2'd1, 5'd9 },  // N mem15 -> full
      '{4'b1000, 1'b0, 5'd16, 4'b0111, 2'b11, 2'd2, 5'd10, 2'd3, 5'd11},  // O pop+push refused
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b01, 2'd3, 5'd15, 2'd0, 5'd0 },  // P
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // Q rob19 dropped
      '{4'b0100, 1'b0, 5'd0,  4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // R0 br rob2
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b01, 2'd2, 5'd2,  2'd0, 5'd0 },  // R1 rr -> 3
      '{4'b0111, 1'b0, 5'd20, 4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // R three queued
      '{4'b0001, 1'b1, 5'd24, 4'b0000, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // S flush
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // T after flush
      '{4'b1001, 1'b0, 5'd0,  4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 },  // V alu0 mem3
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b11, 2'd0, 5'd0,  2'd3, 5'd3 },  // W rr back to 0
      '{4'b0000, 1'b0, 5'd0,  4'b1111, 2'b00, 2'd0, 5'd0,  2'd0, 5'd0 }   // X
    };

    drive(4'b0000, 5'd0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset wb_valid", 32'(bus.wb_valid), 32'd0);
    check_slot("reset", 0, 1'b0, 2'd0, 5'd0);
    check_slot("reset", 1, 1'b0, 2'd0, 5'd0);
    rst = 1'b1;
    #1;
    chk("release req_ready", 32'(bus.req_ready), 32'hF);
    $display("reset: req_ready=%b wb_valid=%b", bus.req_ready, bus.wb_valid);

    // Single alu push: broadcast the following cycle, then bus idle.
    bus.req_valid[0]          = 1'b1;
    bus.req_rob_idx[4:0]      = 5'd3;
    bus.req_rd_addr[4:0]      = 5'd5;
    bus.req_data[31:0]        = 32'hDEAD_BEEF;
    #1;
    chk("single same-cycle wb_valid", 32'(bus.wb_valid), 32'd0);
    @(posedge clk);
    #1;
    drive(4'b0000, 5'd0);
    #1;
    chk("single wb_valid", 32'(bus.wb_valid), 32'h1);
    chk("single src", 32'(bus.wb_src[1:0]), 32'd0);
    chk("single rob", 32'(bus.wb_rob_idx[4:0]), 32'd3);
    chk("single rd", 32'(bus.wb_rd_addr[4:0]), 32'd5);
    chk("single data", bus.wb_data[31:0], 32'hDEAD_BEEF);
    $display("single push: wb_valid=%b rob=%0d rd=%0d data=%h",
             bus.wb_valid, bus.wb_rob_idx[4:0], bus.wb_rd_addr[4:0], bus.wb_data[31:0]);
    @(posedge clk);
    #1;
    chk("single after wb_valid", 32'(bus.wb_valid), 32'd0);

    // Table: fresh reset so rr_ptr starts at 0.
    do_reset();
    for (int r = 0; r < 25; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      drive(vecs[r].valid, vecs[r].base);
      flush = vecs[r].flush;
      #1;
      chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(vecs[r].exp_ready));
      chk({tag, " wb_valid"}, 32'(bus.wb_valid), 32'(vecs[r].exp_wbv));
      check_slot(tag, 0, vecs[r].exp_wbv[0], vecs[r].src0, vecs[r].rob0);
      check_slot(tag, 1, vecs[r].exp_wbv[1], vecs[r].src1, vecs[r].rob1);
      $display("row %0d: valid=%b flush=%b ready=%b wb_valid=%b src=%h rob=%h",
               r, vecs[r].valid, vecs[r].flush, bus.req_ready, bus.wb_valid,
               bus.wb_src, bus.wb_rob_idx);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    drive(4'b0000, 5'd0);

    // Asynchronous reset in the middle of a pending broadcast.
    drive(4'b0001, 5'd9);
    @(posedge clk);
    #1;
    drive(4'b0000, 5'd0);
    #1;
    chk("midrst before wb_valid", 32'(bus.wb_valid), 32'h1);
    rst = 1'b0;
    #1;
    chk("midrst wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("midrst req_ready", 32'(bus.req_ready), 32'd0);
    check_slot("midrst", 0, 1'b0, 2'd0, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst release wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("midrst release req_ready", 32'(bus.req_ready), 32'hF);
    $display("mid reset: wb_valid=%b req_ready=%b", bus.wb_valid, bus.req_ready);

`ifdef CDB_ARBITER_PERF_EN
    // alu, mul, br pushed together: br waits exactly one cycle.
    do_reset();
    drive(4'b0111, 5'd0);
    @(posedge clk);
    #1;
    drive(4'b0000, 5'd0);
    for (int i = 0; i < NUM_REQ; i++)
      chk($sformatf("perf0 req%0d", i), perf[i*32 +: 32], 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      chk($sformatf("perf1 req%0d", i), perf[i*32 +: 32], (i == 2) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    chk("perf2 br", perf[2*32 +: 32], 32'd1);
    $display("perf: br stall count=%0d", perf[2*32 +: 32]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
